xlink_bus_arbiter: RTL and testbench



---
 rtl/xlink_bus_pkg.sv | 16 +
 rtl/rr_arb2.sv | 36 +++
 rtl/xlink_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_xlink_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xlink_bus_pkg.sv
// Shared state encoding and size constants for the XLink register-bus arbiter.
package xlink_bus_pkg;

  localparam int unsigned AddrW          = 31;
  localparam int unsigned DataW          = 32;
  localparam int unsigned MaxReadLatency = 7;
  localparam int unsigned LatCntW        = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StWait,
    StAck
  } bus_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter with registered last-grant pointer. With XLINK_BUS_ARB_FIXED_PRIO_EN
// defined it reduces to fixed priority (master 0 wins) and the pointer is not built.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       owner_i,
  output logic       gnt_idx_o
);

`ifdef XLINK_BUS_ARB_FIXED_PRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clk_i, reset_i, upd_i, owner_i};
  assign gnt_idx_o  = ~req_i[0] & req_i[1];
`else
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = owner_i;
  end

  // Pointer resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) last_q <= 1'b1;
    else         last_q <= last_d;
  end

  always_comb begin
    if (&req_i) gnt_idx_o = ~last_q;
    else        gnt_idx_o = req_i[1];
  end
`endif

endmodule

// File: rtl/xlink_bus_arbiter.sv
// Two-master register-bus arbiter/sequencer: single-cycle strobes, fixed read latency,
// one-cycle ack to the owner. XLINK_BUS_ARB_FIXED_PRIO_EN selects fixed priority.
module xlink_bus_arbiter
  import xlink_bus_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = AddrW,
  parameter int unsigned DATA_W       = DataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_bus_wr,
  input  logic [DATA_W-1:0] data_bus_rd,
  output logic              wr_strobe,
  output logic              rd_strobe
);

  localparam logic [LatCntW-1:0] RdLat = LatCntW'(READ_LATENCY);

  bus_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LatCntW-1:0]  cnt_q, cnt_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic                rd_strobe_q, rd_strobe_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                capture;
  logic                gnt_idx;

  rr_arb2 u_arb (
    .clk_i     (clk),
    .reset_i   (reset),
    .req_i     ({m1_req, m0_req}),
    .upd_i     (state_q == StAck),
    .owner_i   (owner_q),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    capture     = 1'b0;

    case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          owner_d     = gnt_idx;
          we_d        = gnt_idx ? m1_we    : m0_we;
          addr_d      = gnt_idx ? m1_addr  : m0_addr;
          wdata_d     = gnt_idx ? m1_wdata : m0_wdata;
          wr_strobe_d = we_d;
          rd_strobe_d = ~we_d;
          state_d     = StStrobe;
        end
      end
      StStrobe: begin
        cnt_d = LatCntW'(1);
        if (we_q) begin
          state_d = StAck;
        end else if (RdLat == '0) begin
          capture = 1'b1;
          state_d = StAck;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == RdLat) begin
          capture = 1'b1;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Ack is registered, so it is raised on the transition into StAck.
    if (state_d == StAck) begin
      m0_ack_d = ~owner_q;
      m1_ack_d = owner_q;
    end

    if (capture) begin
      if (owner_q) m1_rdata_d = data_bus_rd;
      else         m0_rdata_d = data_bus_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign addr_bus    = addr_q;
  assign data_bus_wr = wdata_q;
  assign wr_strobe   = wr_strobe_q;
  assign rd_strobe   = rd_strobe_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_xlink_bus_arbiter.sv
// Bench for xlink_bus_arbiter: two instances (read latency 3 and 0) exercised in turn
// against a transaction-level model of arbitration order, latencies and held read data.
module tb_xlink_bus_arbiter;

  localparam int unsigned AW = 31;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          ack   [2][2];
  logic [DW-1:0] rdata [2][2];
  logic [AW-1:0] abus  [2];
  logic [DW-1:0] wbus  [2];
  logic [DW-1:0] rbus  [2];
  logic          wstb  [2];
  logic          rstb  [2];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    xlink_bus_arbiter #(
      .READ_LATENCY (g == 0 ? 3 : 0),
      .ADDR_W       (AW),
      .DATA_W       (DW)
    ) u_dut (
      .clk         (clk),
      .reset       (rst[g]),
      .m0_req      (req[g][0]),
      .m0_we       (we[g][0]),
      .m0_addr     (addr[g][0]),
      .m0_wdata    (wdata[g][0]),
      .m0_ack      (ack[g][0]),
      .m0_rdata    (rdata[g][0]),
      .m1_req      (req[g][1]),
      .m1_we       (we[g][1]),
      .m1_addr     (addr[g][1]),
      .m1_wdata    (wdata[g][1]),
      .m1_ack      (ack[g][1]),
      .m1_rdata    (rdata[g][1]),
      .addr_bus    (abus[g]),
      .data_bus_wr (wbus[g]),
      .data_bus_rd (rbus[g]),
      .wr_strobe   (wstb[g]),
      .rd_strobe   (rstb[g])
    );
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int          d        = 0;

  // Reference model: pending requests, fairness memory, held read data, held bus values.
  bit            p_v     [2];
  bit            p_we    [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  bit            last;
  logic [DW-1:0] m_rd    [2];
  logic [AW-1:0] m_abus;
  logic [DW-1:0] m_wbus;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d got=%0h exp=%0h t=%0t", tag, d, got, exp, $time);
    end
  endtask

  function automatic int rl_of(input int dd);
    return (dd == 0) ? 3 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int m, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] v);
    p_v[m] = 1'b1; p_we[m] = w; p_addr[m] = a; p_wdata[m] = v;
    req[d][m] = 1'b1; we[d][m] = w; addr[d][m] = a; wdata[d][m] = v;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "/wstb"}, 64'(wstb[d]), 64'd0);
    check_eq({tag, "/rstb"}, 64'(rstb[d]), 64'd0);
    check_eq({tag, "/ack0"}, 64'(ack[d][0]), 64'd0);
    check_eq({tag, "/ack1"}, 64'(ack[d][1]), 64'd0);
    check_eq({tag, "/abus"}, 64'(abus[d]), 64'(m_abus));
    check_eq({tag, "/wbus"}, 64'(wbus[d]), 64'(m_wbus));
  endtask

  task automatic do_reset();
    rst[d] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0;
      p_v[m] = 1'b0; m_rd[m] = '0;
    end
    rbus[d] = $urandom;
    step();
    rst[d] = 1'b0;
    last   = 1'b1;
    m_abus = '0;
    m_wbus = '0;
    check_quiet("rst");
    check_eq("rst/rdata0", 64'(rdata[d][0]), 64'd0);
    check_eq("rst/rdata1", 64'(rdata[d][1]), 64'd0);
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after the ack (or one cycle later).
  task automatic do_round(input bit drop, input logic [DW-1:0] rv, output int obs);
    int w;
    int capoff;
    int ackoff;
    obs = -1;
    if (!p_v[0] && !p_v[1]) begin
      check_quiet("idle");
      step();
      return;
    end
`ifdef XLINK_BUS_ARB_FIXED_PRIO_EN
    w = p_v[0] ? 0 : 1;
`else
    w = (p_v[0] && p_v[1]) ? (last ? 0 : 1) : (p_v[0] ? 0 : 1);
`endif
    check_quiet("pre");
    capoff  = 1 + rl_of(d);
    ackoff  = p_we[w] ? 2 : 2 + rl_of(d);
    rbus[d] = rv ^ ($urandom | 32'h1);
    for (int k = 1; k <= ackoff; k++) begin
      step();
      rbus[d] = (!p_we[w] && k == capoff) ? rv : (rv ^ ($urandom | 32'h1));
      if (k == 1) begin
        m_abus = p_addr[w];
        m_wbus = p_wdata[w];
        check_eq("stb/wstb", 64'(wstb[d]), 64'(p_we[w]));
        check_eq("stb/rstb", 64'(rstb[d]), 64'(!p_we[w]));
        check_eq("stb/abus", 64'(abus[d]), 64'(m_abus));
        check_eq("stb/wbus", 64'(wbus[d]), 64'(m_wbus));
        check_eq("stb/ack0", 64'(ack[d][0]), 64'd0);
        check_eq("stb/ack1", 64'(ack[d][1]), 64'd0);
      end else if (k < ackoff) begin
        check_quiet("wait");
      end else begin
        if (!p_we[w]) m_rd[w] = rv;
        obs = ack[d][1] ? 1 : 0;
        check_eq("ack/own", 64'(ack[d][w]), 64'd1);
        check_eq("ack/other", 64'(ack[d][1-w]), 64'd0);
        check_eq("ack/wstb", 64'(wstb[d]), 64'd0);
        check_eq("ack/rstb", 64'(rstb[d]), 64'd0);
        check_eq("ack/rdata0", 64'(rdata[d][0]), 64'(m_rd[0]));
        check_eq("ack/rdata1", 64'(rdata[d][1]), 64'(m_rd[1]));
        last      = (w == 1);
        p_v[w]    = 1'b0;
        req[d][w] = 1'b0;
      end
      if (k == 2 && drop) req[d][w] = 1'b0;
    end
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int obs;
    int exp_w;
    for (int dd = 0; dd < 2; dd++) begin
      rst[dd]  = 1'b1;
      rbus[dd] = '0;
      for (int m = 0; m < 2; m++) begin
        req[dd][m] = 1'b0; we[dd][m] = 1'b0; addr[dd][m] = '0; wdata[dd][m] = '0;
      end
    end

    for (int dd = 0; dd < 2; dd++) begin
      d = dd;
      do_reset();

      // Directed: m0 write, m1 read of 0xCAFE, m0 read with req dropped after strobe.
      post(0, 1'b1, AW'(32'h10), 32'h5);
      do_round(1'b0, '0, obs);
      check_eq("wr/owner", 64'(obs), 64'd0);
      post(1, 1'b0, AW'(32'h40), 32'h0);
      do_round(1'b0, 32'hCAFE, obs);
      check_eq("rd/cafe", 64'(rdata[d][1]), 64'hCAFE);
      post(0, 1'b0, AW'(32'h22), $urandom);
      do_round(1'b1, $urandom, obs);
      check_eq("drop/owner", 64'(obs), 64'd0);
      do_round(1'b0, '0, obs);
      do_round(1'b0, '0, obs);

      // Both masters request continuously for six transactions.
      do_reset();
      for (int i = 0; i < 6; i++) begin
        for (int m = 0; m < 2; m++)
          if (!p_v[m]) post(m, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        do_round(1'b0, $urandom, obs);
`ifdef XLINK_BUS_ARB_FIXED_PRIO_EN
        exp_w = 0;
`else
        exp_w = i % 2;
`endif
        check_eq("order", 64'(obs), 64'(exp_w));
      end

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
        for (int m = 0; m < 2; m++)
          if (!p_v[m] && $urandom_range(0, 2) != 0)
            post(m, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        do_round($urandom_range(0, 5) == 0, $urandom, obs);
      end

      // Reset while waiting on read data, then a fresh m1 read.
      if (rl_of(d) > 0) begin
        do_reset();
        post(1, 1'b0, AW'(32'h55), 32'h0);
        step();
        check_eq("mr/rstb", 64'(rstb[d]), 64'd1);
        step();
        check_eq("mr/ack1", 64'(ack[d][1]), 64'd0);
        do_reset();
        post(1, 1'b0, AW'(32'h56), 32'h0);
        do_round(1'b0, $urandom, obs);
        check_eq("mr/owner", 64'(obs), 64'd1);
      end
      rst[d] = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
